disk_uart_sequencer: RTL and testbench
======================================

// Module: disk_uart_sequencer
// PURPOSE
//   Sequences sector transfers between the CPU-side sector buffer and the host disk image over the UART byte link.
//   Frames each command, streams sector data, and checks the host reply.
//   Sits between the CPU disk port and the UART tx/rx byte engines.
//   One command in flight; busy until done or error.
// PARAMETERS
//   SECTOR_BYTES  512        bytes per sector transfer
//   ADDR_W        9          sector buffer address width; SECTOR_BYTES <= 2**ADDR_W
//   TIMEOUT_CYC   1000000    max idle clk cycles waiting for an rx byte
//   TO_W          20         timeout counter width
// PORTS
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       reset: asynchronous, active-low
//   cmd_valid  in   1       command request
//   cmd_ready  out  1       high only in IDLE; command accepted when cmd_valid & cmd_ready
//   cmd_write  in   1       1 = write sector to host, 0 = read sector
//   cmd_lba    in   32      sector number; latched on accept
//   done       out  1       one-cycle pulse: transfer completed OK
//   error      out  1       sticky: high from ERR until the next accepted command
//   busy       out  1       high in any state other than IDLE
//   tx_data    out  8       byte to UART transmitter
//   tx_valid   out  1       byte offered; held stable until tx_ready
//   tx_ready   in   1       transmitter accepts tx_data this cycle
//   rx_data    in   8       received byte
//   rx_valid   in   1       one-cycle strobe: rx_data is valid
//   buf_addr   out  ADDR_W  sector buffer address
//   buf_wdata  out  8       buffer write data
//   buf_we     out  1       buffer write enable
//   buf_rdata  in   8       buffer read data, valid 1 cycle after buf_addr
// BEHAVIOUR
//   Reset: IDLE; cmd_ready=1; done, error, busy, tx_valid and buf_we = 0; tx_data, buf_addr and buf_wdata = 0; counters = 0.
//   Frame: opcode (0x52 'R' / 0x57 'W'), then cmd_lba bytes MSB first.
//   FSM:
//     IDLE      -> SEND_HDR on accept; clears error.
//     SEND_HDR  -> after 5th byte handshake: SEND_DATA if write, else RECV_DATA.
//     SEND_DATA -> prefetches buf_addr=0..N-1; a byte goes to the transmitter only after buf_rdata latency.
//                  Sends bytes in address order; tx_valid never drops while a byte is pending.
//                  Goes to WAIT_ACK after byte N-1 handshake.
//     WAIT_ACK  -> 0x06 gives DONE; 0x15 or any other byte gives ERR.
//     RECV_DATA -> each rx_valid writes rx_data to buf_addr=k (buf_we 1 cycle), k++.
//                  Goes to DONE after byte N-1.
//     DONE      -> done=1 for one cycle, then IDLE.
//     ERR       -> error=1, then IDLE next cycle; error stays high.
//   Timeout:
//     Counter runs in WAIT_ACK and RECV_DATA and clears on each rx_valid.
//     Reaching TIMEOUT_CYC-1 gives ERR.
//     The timeout counter saturates and never wraps.
//   rx_valid outside WAIT_ACK/RECV_DATA is ignored.
//   An accepted command is never dropped.
//   cmd_valid while busy is not accepted; it waits for cmd_ready.
//   Byte index k wraps only via FSM exit at SECTOR_BYTES-1; it never reaches SECTOR_BYTES.
//   rst_n low mid-transfer aborts immediately to IDLE.
//   An abort leaves a partial buffer and does not pulse done.
// CONFIGURATION
//   DISK_CKSUM_EN defined:
//     Write: SEND_CK state sends the XOR of all data bytes after the data, before WAIT_ACK.
//     Read: RECV_CK state takes one extra byte after the data.
//     Mismatch gives ERR (buffer already written); match gives DONE.
//   DISK_CKSUM_EN undefined:
//     No checksum byte in either direction.
//     SEND_CK and RECV_CK states and the XOR register are absent.
// TESTING (SECTOR_BYTES=4, TIMEOUT_CYC=64 unless noted)
//   Read: lba=0x00000102; rx 11,22,33,44 -> tx 52,00,00,01,02; buffer[0..3]=11,22,33,44; one done pulse.
//   Write: buffer=A0,A1,A2,A3, lba=5; tx_ready toggled 1/0 every cycle; rx 06
//     -> tx 57,00,00,00,05,A0,A1,A2,A3; done.
//   Write with NAK: rx 15 -> error=1, no done.
//     Next read command clears error and completes OK.
//   Timeout: read command with only 2 rx bytes -> ERR 64 cycles after last byte; cmd_ready back next cycle.
//   Reset mid-RECV_DATA after 2 bytes -> all outputs at reset values.
//     A new read completes normally.
//   DISK_CKSUM_EN: read 01,02,03,04 + cksum 04 -> done; cksum 05 -> error.
//     Write appends 0x00 for A0..A3.

Source files
------------

// File: rtl/disk_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : disk_uart_sequencer
// Brief    : Frames sector read/write commands to the host disk image over the
//            UART byte link, streams sector data and checks the host reply.
//            Optional trailing XOR checksum byte: define DISK_CKSUM_EN.
// Revision : 1.0
// ============================================================================
module disk_uart_sequencer #(
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_W       = 9,
    parameter int TIMEOUT_CYC  = 1000000,
    parameter int TO_W         = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_lba,
    output logic              done,
    output logic              error,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              buf_we,
    input  logic [7:0]        buf_rdata
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SEND_HDR  = 4'd1,
        SEND_DATA = 4'd2,
        WAIT_ACK  = 4'd3,
        RECV_DATA = 4'd4,
        DONE      = 4'd5,
        ERR       = 4'd6
`ifdef DISK_CKSUM_EN
        ,
        SEND_CK   = 4'd7,
        RECV_CK   = 4'd8
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SECTOR_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic               write_q, write_d;
    logic [31:0]        lba_q, lba_d;
    logic [2:0]         hdr_q, hdr_d;
    logic [ADDR_W-1:0]  k_q, k_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               error_q, error_d;
    logic [7:0]         txd_q, txd_d;
    logic               txv_q, txv_d;
    logic               rdv_q, rdv_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [7:0]         hdr_byte;
`ifdef DISK_CKSUM_EN
    logic [7:0]         cksum_q, cksum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            lba_q   <= '0;
            hdr_q   <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            to_q    <= '0;
            error_q <= 1'b0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            rdv_q   <= 1'b0;
            wdata_q <= '0;
            we_q    <= 1'b0;
`ifdef DISK_CKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            lba_q   <= lba_d;
            hdr_q   <= hdr_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            to_q    <= to_d;
            error_q <= error_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            rdv_q   <= rdv_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
`ifdef DISK_CKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    // Header: opcode then LBA most-significant byte first
    always_comb begin
        hdr_byte = lba_q[7:0];
        case (hdr_q)
            3'd0:    hdr_byte = write_q ? 8'h57 : 8'h52;
            3'd1:    hdr_byte = lba_q[31:24];
            3'd2:    hdr_byte = lba_q[23:16];
            3'd3:    hdr_byte = lba_q[15:8];
            default: hdr_byte = lba_q[7:0];
        endcase
    end

    always_comb begin
        tx_data  = txd_q;
        tx_valid = txv_q;
        if (state_q == SEND_HDR) begin
            tx_data  = hdr_byte;
            tx_valid = 1'b1;
        end
`ifdef DISK_CKSUM_EN
        if (state_q == SEND_CK) begin
            tx_data  = cksum_q;
            tx_valid = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        lba_d   = lba_q;
        hdr_d   = hdr_q;
        k_d     = k_q;
        addr_d  = addr_q;
        to_d    = '0;
        error_d = error_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        rdv_d   = rdv_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
`ifdef DISK_CKSUM_EN
        cksum_d = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SEND_HDR;
                    write_d = cmd_write;
                    lba_d   = cmd_lba;
                    hdr_d   = '0;
                    k_d     = '0;
                    addr_d  = '0;
                    error_d = 1'b0;
                    txv_d   = 1'b0;
                    rdv_d   = 1'b0;
`ifdef DISK_CKSUM_EN
                    cksum_d = '0;
`endif
                end
            end
            SEND_HDR: begin
                if (tx_ready) begin
                    if (hdr_q == 3'd4) begin
                        hdr_d   = '0;
                        state_d = write_q ? SEND_DATA : RECV_DATA;
                    end else begin
                        hdr_d = hdr_q + 3'd1;
                    end
                end
            end
            // rdv_q marks that buf_addr has been stable for a cycle, so
            // buf_rdata now belongs to index k.
            SEND_DATA: begin
                if (txv_q) begin
                    if (tx_ready) begin
                        txv_d = 1'b0;
                        rdv_d = 1'b0;
`ifdef DISK_CKSUM_EN
                        cksum_d = cksum_q ^ txd_q;
`endif
                        if (k_q == LAST_IDX) begin
                            k_d = '0;
`ifdef DISK_CKSUM_EN
                            state_d = SEND_CK;
`else
                            state_d = WAIT_ACK;
`endif
                        end else begin
                            k_d    = k_q + 1'b1;
                            addr_d = k_q + 1'b1;
                        end
                    end
                end else if (rdv_q) begin
                    txd_d = buf_rdata;
                    txv_d = 1'b1;
                end else begin
                    rdv_d = 1'b1;
                end
            end
`ifdef DISK_CKSUM_EN
            SEND_CK: begin
                if (tx_ready) begin
                    state_d = WAIT_ACK;
                end
            end
            RECV_CK: begin
                if (rx_valid) begin
                    state_d = (rx_data == cksum_q) ? DONE : ERR;
                end else if (to_q == TO_LAST) begin
                    to_d    = to_q;
                    state_d = ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
`endif
            WAIT_ACK: begin
                if (rx_valid) begin
                    state_d = (rx_data == 8'h06) ? DONE : ERR;
                end else if (to_q == TO_LAST) begin
                    to_d    = to_q;
                    state_d = ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            RECV_DATA: begin
                if (rx_valid) begin
                    we_d    = 1'b1;
                    wdata_d = rx_data;
                    addr_d  = k_q;
`ifdef DISK_CKSUM_EN
                    cksum_d = cksum_q ^ rx_data;
`endif
                    if (k_q == LAST_IDX) begin
                        k_d = '0;
`ifdef DISK_CKSUM_EN
                        state_d = RECV_CK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else if (to_q == TO_LAST) begin
                    to_d    = to_q;
                    state_d = ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == ERR) begin
            error_d = 1'b1;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign error     = error_q;
    assign buf_addr  = addr_q;
    assign buf_wdata = wdata_q;
    assign buf_we    = we_q;

endmodule
`default_nettype wire

// File: tb/tb_disk_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_disk_uart_sequencer
// Brief    : Directed bench for disk_uart_sequencer (4-byte sectors,
//            64-cycle timeout); follows DISK_CKSUM_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_disk_uart_sequencer;

    localparam int SB = 4;
    localparam int AW = 2;
    localparam int TO = 64;
    localparam int TW = 7;
`ifdef DISK_CKSUM_EN
    localparam int NW = 10;
`else
    localparam int NW = 9;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [31:0]   cmd_lba = '0;
    logic          done, error, busy;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_wdata;
    logic          buf_we;
    logic [7:0]    buf_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    disk_uart_sequencer #(
        .SECTOR_BYTES(SB), .ADDR_W(AW), .TIMEOUT_CYC(TO), .TO_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_lba(cmd_lba),
        .done(done), .error(error), .busy(busy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata)
    );

    // Sector buffer model with one-cycle read latency
    logic [7:0] mem [0:SB-1];
    always @(posedge clk) begin
        buf_rdata <= mem[buf_addr];
        if (buf_we) mem[buf_addr] = buf_wdata;
    end

    logic tog = 1'b0;
    always @(posedge clk) begin
        #1;
        tx_ready = tog ? ~tx_ready : 1'b1;
    end

    logic [7:0] tx_log [$];
    int         done_cnt = 0;
    int         viol = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_d = '0;
    always @(negedge clk) begin
        if (pend && !(tx_valid === 1'b1 && tx_data === pend_d)) viol++;
        if (done === 1'b1) done_cnt++;
        if (tx_valid === 1'b1 && tx_ready) tx_log.push_back(tx_data);
        pend   = (tx_valid === 1'b1) && !tx_ready;
        pend_d = tx_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] tx_packed();
        logic [79:0] v = '0;
        foreach (tx_log[i]) v = {v[71:0], tx_log[i]};
        return v;
    endfunction

    function automatic logic [79:0] out_vec();
        return {58'd0, cmd_ready, busy, done, error, tx_valid, buf_we, tx_data, buf_wdata, buf_addr};
    endfunction

    task automatic issue(input logic w, input logic [31:0] lba);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_lba   = lba;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_bound", {79'd0, t < 200}, 80'd1);
        check("busy_after_accept", {78'd0, busy, cmd_ready}, 80'b10);
    endtask

    task automatic wait_tx(input int n);
        int t = 0;
        while (tx_log.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("tx_count", 80'(tx_log.size()), 80'(n));
        repeat (3) @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_read(input logic [31:0] bytes, input logic [7:0] ck_xor);
        logic [7:0] x = '0;
        for (int i = 0; i < SB; i++) begin
            rx_byte(bytes[31-8*i -: 8]);
            x = x ^ bytes[31-8*i -: 8];
            @(negedge clk);
        end
`ifdef DISK_CKSUM_EN
        rx_byte(x ^ ck_xor);
`endif
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("idle_bound", {79'd0, busy}, 80'd0);
    endtask

    initial begin
        int          d0;
        logic [79:0] exp_w;

        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), {58'd0, 6'b100000, 18'd0});
        rst_n = 1'b1;
        @(negedge clk);

        // Read, lba 0x102
        d0 = done_cnt;
        tx_log.delete();
        issue(1'b0, 32'h0000_0102);
        wait_tx(5);
        send_read(32'h1122_3344, 8'h00);
        wait_idle();
        check("read_tx", tx_packed(), 80'h52_00_00_01_02);
        check("read_buf", {48'd0, mem[0], mem[1], mem[2], mem[3]}, 80'h1122_3344);
        check("read_done", 80'(done_cnt - d0), 80'd1);
        check("read_error", {79'd0, error}, 80'd0);

        // Write with ready toggling, ACK
        mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
        exp_w = 80'h57_00_00_00_05_A0_A1_A2_A3;
`ifdef DISK_CKSUM_EN
        exp_w = exp_w << 8;
`endif
        tog = 1'b1;
        d0 = done_cnt;
        tx_log.delete();
        issue(1'b1, 32'd5);
        wait_tx(NW);
        rx_byte(8'h06);
        wait_idle();
        tog = 1'b0;
        check("write_tx", tx_packed(), exp_w);
        check("write_done", 80'(done_cnt - d0), 80'd1);
        check("write_error", {79'd0, error}, 80'd0);
        check("tx_hold_stable", 80'(viol), 80'd0);

        // Write answered with NAK
        d0 = done_cnt;
        tx_log.delete();
        issue(1'b1, 32'd5);
        wait_tx(NW);
        rx_byte(8'h15);
        wait_idle();
        check("nak_error", {79'd0, error}, 80'd1);
        check("nak_no_done", 80'(done_cnt - d0), 80'd0);
        repeat (3) @(negedge clk);
        check("nak_sticky", {78'd0, error, cmd_ready}, 80'b11);

        // Next read clears error
        d0 = done_cnt;
        tx_log.delete();
        issue(1'b0, 32'hDEAD_BEEF);
        check("error_cleared", {79'd0, error}, 80'd0);
        wait_tx(5);
        send_read(32'h0506_0708, 8'h00);
        wait_idle();
        check("read2_tx", tx_packed(), 80'h52_DE_AD_BE_EF);
        check("read2_buf", {48'd0, mem[0], mem[1], mem[2], mem[3]}, 80'h0506_0708);
        check("read2_done", 80'(done_cnt - d0), 80'd1);

        // Timeout after two bytes: ERR 64 cycles after the last byte
        d0 = done_cnt;
        tx_log.delete();
        issue(1'b0, 32'h77);
        wait_tx(5);
        rx_byte(8'h9A);
        @(negedge clk);
        rx_byte(8'hBC);
        repeat (63) @(negedge clk);
        check("to_before", {78'd0, error, busy}, 80'b01);
        @(negedge clk);
        check("to_err", {78'd0, error, cmd_ready}, 80'b10);
        @(negedge clk);
        check("to_idle", {78'd0, error, cmd_ready}, 80'b11);
        check("to_no_done", 80'(done_cnt - d0), 80'd0);
        check("to_partial", {64'd0, mem[0], mem[1]}, 80'h9ABC);

        // Reset in the middle of RECV_DATA
        d0 = done_cnt;
        tx_log.delete();
        issue(1'b0, 32'h1);
        wait_tx(5);
        rx_byte(8'h01);
        @(negedge clk);
        rx_byte(8'h02);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", out_vec(), {58'd0, 6'b100000, 18'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_partial", {64'd0, mem[0], mem[1]}, 80'h0102);
        check("abort_no_done", 80'(done_cnt - d0), 80'd0);
        d0 = done_cnt;
        tx_log.delete();
        issue(1'b0, 32'h2);
        wait_tx(5);
        send_read(32'hC1C2_C3C4, 8'h00);
        wait_idle();
        check("post_abort_tx", tx_packed(), 80'h52_00_00_00_02);
        check("post_abort_buf", {48'd0, mem[0], mem[1], mem[2], mem[3]}, 80'hC1C2_C3C4);
        check("post_abort_done", 80'(done_cnt - d0), 80'd1);

`ifdef DISK_CKSUM_EN
        // Corrupted checksum byte on a read
        d0 = done_cnt;
        tx_log.delete();
        issue(1'b0, 32'h3);
        wait_tx(5);
        send_read(32'h0102_0304, 8'h01);
        wait_idle();
        check("ck_bad_error", {79'd0, error}, 80'd1);
        check("ck_bad_no_done", 80'(done_cnt - d0), 80'd0);
        check("ck_bad_buf", {48'd0, mem[0], mem[1], mem[2], mem[3]}, 80'h0102_0304);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
